// File: rtl/hc161_counter.sv
// -----------------------------------------------------------------------------
// hc161_counter
//   Synchronous presettable up/down modulo-N counter in the style of the
//   74HC161/191. Cascadable through ENT/RCO; TC is a registered one-cycle
//   pulse that follows every wrap and clocks the downstream JK stage.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   Clk   in   1      clock, rising edge
//   R     in   1      asynchronous reset, active-low
//   LD_N  in   1      synchronous parallel load, active-low (highest priority)
//   ENP   in   1      parallel (local) count enable
//   ENT   in   1      trickle (cascade) count enable, also gates RCO
//   UD    in   1      direction: 1 = up, 0 = down
//   D     in   WIDTH  parallel load data (clamped to MODULUS-1)
//   Q     out  WIDTH  counter state, registered
//   RCO   out  1      ripple carry, combinational: ENT & terminal count
//   TC    out  1      registered pulse, high for the cycle after a wrap
// -----------------------------------------------------------------------------
module hc161_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             LD_N,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC
);

    // Largest legal state; also the wrap target when counting down.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tc_reg;
    logic             tc_next;
    logic             term;
    logic             count_en;
    logic [WIDTH-1:0] load_val;

    // Terminal count depends on direction so RCO reacts to UD combinationally.
    always_comb begin
        term     = UD ? (q_reg == MAX_VAL) : (q_reg == '0);
        count_en = ENP & ENT;
        // Out-of-range load data is clamped so Q never leaves 0..MODULUS-1.
        load_val = (D > MAX_VAL) ? MAX_VAL : D;
    end

    // Next-state: load beats count beats hold. TC only follows a counted wrap.
    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (!LD_N) begin
            q_next = load_val;
        end else if (count_en) begin
            if (UD) begin
                q_next = term ? '0 : (q_reg + WIDTH'(1));
            end else begin
                q_next = term ? MAX_VAL : (q_reg - WIDTH'(1));
            end
            tc_next = term;
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    assign Q   = q_reg;
    assign TC  = tc_reg;
    // Standard cascade rule: independent of ENP and LD_N.
    assign RCO = ENT & term;

endmodule

// File: tb/tb_hc161_counter.sv
module tb_hc161_counter;

    logic clk;
    logic R;

    // Instance A: WIDTH=4, MODULUS=16
    logic       a_ld_n, a_enp, a_ent, a_ud;
    logic [3:0] a_d, a_q;
    logic       a_rco, a_tc;

    // Instance B: WIDTH=4, MODULUS=10
    logic       b_ld_n, b_enp, b_ent, b_ud;
    logic [3:0] b_d, b_q;
    logic       b_rco, b_tc;

    // Cascade: two MODULUS=16 stages, lower RCO feeds upper ENT
    logic       c_ld_n, c_enp, c_ent;
    logic [3:0] c_q_lo, c_q_hi;
    logic       c_rco_lo, c_rco_hi, c_tc_lo, c_tc_hi;
    logic       jk_q;

    int checks;
    int failures;

    hc161_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .Clk(clk), .R(R), .LD_N(a_ld_n), .ENP(a_enp), .ENT(a_ent), .UD(a_ud),
        .D(a_d), .Q(a_q), .RCO(a_rco), .TC(a_tc)
    );

    hc161_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .Clk(clk), .R(R), .LD_N(b_ld_n), .ENP(b_enp), .ENT(b_ent), .UD(b_ud),
        .D(b_d), .Q(b_q), .RCO(b_rco), .TC(b_tc)
    );

    hc161_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .Clk(clk), .R(R), .LD_N(c_ld_n), .ENP(c_enp), .ENT(c_ent), .UD(1'b1),
        .D(4'h0), .Q(c_q_lo), .RCO(c_rco_lo), .TC(c_tc_lo)
    );

    hc161_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .Clk(clk), .R(R), .LD_N(c_ld_n), .ENP(c_enp), .ENT(c_rco_lo), .UD(1'b1),
        .D(4'h0), .Q(c_q_hi), .RCO(c_rco_hi), .TC(c_tc_hi)
    );

    // Downstream JK flip-flop in toggle mode (J=K=1), enabled by upper TC.
    always_ff @(posedge clk or negedge R) begin
        if (!R) jk_q <= 1'b0;
        else if (c_tc_hi) jk_q <= ~jk_q;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b0;
        a_ld_n = 1'b1; a_enp = 1'b0; a_ent = 1'b1; a_ud = 1'b1; a_d = 4'h0;
        b_ld_n = 1'b1; b_enp = 1'b0; b_ent = 1'b1; b_ud = 1'b0; b_d = 4'h0;
        c_ld_n = 1'b1; c_enp = 1'b0; c_ent = 1'b0;
        #2;
        checks++; if (a_q !== 4'h0) begin failures++; $display("FAIL reset_a_q actual=%0h expected=0", a_q); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL reset_a_tc actual=%0b expected=0", a_tc); end
        checks++; if (a_rco !== 1'b0) begin failures++; $display("FAIL reset_a_rco_up actual=%0b expected=0", a_rco); end
        checks++; if (b_rco !== 1'b1) begin failures++; $display("FAIL reset_b_rco_down actual=%0b expected=1", b_rco); end
        checks++; if ({c_q_hi, c_q_lo} !== 8'h00) begin failures++; $display("FAIL reset_cascade actual=%0h expected=0", {c_q_hi, c_q_lo}); end
        @(negedge clk);
        R = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_count();
        a_enp = 1'b1; a_ent = 1'b1; a_ud = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (a_q !== 4'd9) begin failures++; $display("FAIL midcnt_pre actual=%0d expected=9", a_q); end
        #2 R = 1'b0;
        #1;
        checks++; if (a_q !== 4'd0) begin failures++; $display("FAIL midcnt_q actual=%0d expected=0", a_q); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL midcnt_tc actual=%0b expected=0", a_tc); end
        checks++; if (a_rco !== 1'b0) begin failures++; $display("FAIL midcnt_rco actual=%0b expected=0", a_rco); end
        #1 R = 1'b1;
        tick();
        checks++; if (a_q !== 4'd1) begin failures++; $display("FAIL midcnt_release actual=%0d expected=1", a_q); end
        a_enp = 1'b0;
        $display("test_reset_mid_count done");
    endtask

    task automatic test_up_wrap();
        a_ld_n = 1'b0; a_d = 4'h0;
        tick();
        a_ld_n = 1'b1; a_enp = 1'b1; a_ent = 1'b1; a_ud = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (a_q !== 4'(i % 16)) begin failures++; $display("FAIL up_q[%0d] actual=%0d expected=%0d", i, a_q, i % 16); end
            checks++; if (a_rco !== ((i % 16) == 15)) begin failures++; $display("FAIL up_rco[%0d] actual=%0b expected=%0b", i, a_rco, (i % 16) == 15); end
            checks++; if (a_tc !== (i == 16)) begin failures++; $display("FAIL up_tc[%0d] actual=%0b expected=%0b", i, a_tc, i == 16); end
            tick();
        end
        a_enp = 1'b0;
        $display("test_up_wrap done");
    endtask

    task automatic test_down_mod10();
        logic [3:0] exp_q   [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_rco [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        b_ud = 1'b0; b_enp = 1'b0; b_ent = 1'b1; b_ld_n = 1'b0; b_d = 4'd3;
        tick();
        b_ld_n = 1'b1;
        checks++; if (b_q !== 4'd3) begin failures++; $display("FAIL down_load actual=%0d expected=3", b_q); end
        checks++; if (b_tc !== 1'b0) begin failures++; $display("FAIL down_load_tc actual=%0b expected=0", b_tc); end
        b_enp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (b_q !== exp_q[i]) begin failures++; $display("FAIL down_q[%0d] actual=%0d expected=%0d", i, b_q, exp_q[i]); end
            checks++; if (b_tc !== exp_tc[i]) begin failures++; $display("FAIL down_tc[%0d] actual=%0b expected=%0b", i, b_tc, exp_tc[i]); end
            checks++; if (b_rco !== exp_rco[i]) begin failures++; $display("FAIL down_rco[%0d] actual=%0b expected=%0b", i, b_rco, exp_rco[i]); end
        end
        b_enp = 1'b0;
        $display("test_down_mod10 done");
    endtask

    task automatic test_load_clamp();
        logic [3:0] d_tab [4] = '{4'd10, 4'd9, 4'd15, 4'd0};
        logic [3:0] q_tab [4] = '{4'd9, 4'd9, 4'd9, 4'd0};
        b_enp = 1'b0; b_ld_n = 1'b0; b_d = 4'd12;
        tick();
        checks++; if (b_q !== 4'd9) begin failures++; $display("FAIL clamp12 actual=%0d expected=9", b_q); end
        b_ud = 1'b1; b_enp = 1'b1; b_ent = 1'b1;
        #1;
        checks++; if (b_rco !== 1'b1) begin failures++; $display("FAIL load_term_rco actual=%0b expected=1", b_rco); end
        b_d = 4'd4;
        tick();
        checks++; if (b_q !== 4'd4) begin failures++; $display("FAIL load_wins_q actual=%0d expected=4", b_q); end
        checks++; if (b_tc !== 1'b0) begin failures++; $display("FAIL load_wins_tc actual=%0b expected=0", b_tc); end
        for (int i = 0; i < 4; i++) begin
            b_d = d_tab[i];
            tick();
            checks++; if (b_q !== q_tab[i]) begin failures++; $display("FAIL clamp_d%0d actual=%0d expected=%0d", d_tab[i], b_q, q_tab[i]); end
        end
        b_ld_n = 1'b1; b_enp = 1'b0;
        $display("test_load_clamp done");
    endtask

    task automatic test_hold();
        a_ld_n = 1'b0; a_d = 4'd15; a_enp = 1'b0;
        tick();
        a_ld_n = 1'b1; a_ud = 1'b1; a_ent = 1'b1;
        #1;
        checks++; if (a_rco !== 1'b1) begin failures++; $display("FAIL hold_rco_enp0 actual=%0b expected=1", a_rco); end
        tick();
        checks++; if (a_q !== 4'd15) begin failures++; $display("FAIL hold_q_enp0 actual=%0d expected=15", a_q); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL hold_tc_enp0 actual=%0b expected=0", a_tc); end
        a_ent = 1'b0; a_enp = 1'b1;
        #1;
        checks++; if (a_rco !== 1'b0) begin failures++; $display("FAIL hold_rco_ent0 actual=%0b expected=0", a_rco); end
        tick();
        checks++; if (a_q !== 4'd15) begin failures++; $display("FAIL hold_q_ent0 actual=%0d expected=15", a_q); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL hold_tc_ent0 actual=%0b expected=0", a_tc); end
        a_enp = 1'b0; a_ent = 1'b1; a_ud = 1'b0;
        #1;
        checks++; if (a_rco !== 1'b0) begin failures++; $display("FAIL ud_flip_rco actual=%0b expected=0", a_rco); end
        $display("test_hold done");
    endtask

    task automatic test_cascade();
        logic [7:0] val;
        logic       jk_exp;
        c_ld_n = 1'b0;
        tick();
        c_ld_n = 1'b1; c_enp = 1'b1; c_ent = 1'b1;
        checks++; if ({c_q_hi, c_q_lo} !== 8'h00) begin failures++; $display("FAIL casc_start actual=%0h expected=0", {c_q_hi, c_q_lo}); end
        for (int n = 1; n <= 520; n++) begin
            if (n == 16) begin
                checks++; if (c_rco_lo !== 1'b1 || {c_q_hi, c_q_lo} !== 8'h0F) begin
                    failures++; $display("FAIL casc_pre10 actual=%0h/%0b expected=0f/1", {c_q_hi, c_q_lo}, c_rco_lo);
                end
            end
            tick();
            val = {c_q_hi, c_q_lo};
            jk_exp = (n >= 257) ^ (n >= 513);
            checks++; if (val !== 8'(n % 256)) begin failures++; $display("FAIL casc_q[%0d] actual=%0h expected=%0h", n, val, n % 256); end
            checks++; if (c_tc_hi !== ((n % 256) == 0)) begin failures++; $display("FAIL casc_tc_hi[%0d] actual=%0b expected=%0b", n, c_tc_hi, (n % 256) == 0); end
            checks++; if (jk_q !== jk_exp) begin failures++; $display("FAIL jk_q[%0d] actual=%0b expected=%0b", n, jk_q, jk_exp); end
        end
        c_enp = 1'b0;
        $display("test_cascade done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_reset_mid_count();
        test_up_wrap();
        test_down_mod10();
        test_load_clamp();
        test_hold();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
